// File: rtl/mem_copy_dma_pkg.sv
// rtl/mem_copy_dma_pkg.sv - shared bus widths, DMA state encodings and write-strobe constants
package mem_copy_dma_pkg;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

    localparam logic [1:0] DMA_ST_IDLE = 2'd0;
    localparam logic [1:0] DMA_ST_RD   = 2'd1;
    localparam logic [1:0] DMA_ST_WR   = 2'd2;
    localparam logic [1:0] DMA_ST_FIN  = 2'd3;

    localparam logic [3:0] MEM_WE_READ = 4'b0000;
    localparam logic [3:0] MEM_WE_WORD = 4'b1111;

endpackage

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - bus initiator copying a block of words from source to destination
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = RISCV_ADDR_WIDTH,
    parameter int WORD_WIDTH = RISCV_WORD_WIDTH,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_words_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [ADDR_WIDTH-1:0] m_addr_o,
    output logic [WORD_WIDTH-1:0] m_wdata_o,
    output logic [3:0]            m_we_o,
    input  logic [WORD_WIDTH-1:0] m_rdata_i
);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic                  abort_q, abort_d;
    logic                  err_q, err_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        abort_d = abort_q;
        err_d   = 1'b0;
        case (state_q)
            DMA_ST_IDLE: begin
                abort_d = 1'b0;
                if (start_i) begin
                    if (src_addr_i[1:0] != 2'b00 || dst_addr_i[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else if (len_words_i == '0) begin
                        state_d = DMA_ST_FIN;
                    end else begin
                        src_d   = src_addr_i;
                        dst_d   = dst_addr_i;
                        rem_d   = len_words_i;
                        state_d = DMA_ST_RD;
                    end
                end
            end
            DMA_ST_RD: begin
                abort_d = abort_q | abort_i;
                if (m_ready_i) begin
                    buf_d   = m_rdata_i;
                    src_d   = src_q + ADDR_WIDTH'(4);
                    state_d = DMA_ST_WR;
                end
            end
            DMA_ST_WR: begin
                abort_d = abort_q | abort_i;
                if (m_ready_i) begin
                    dst_d = dst_q + ADDR_WIDTH'(4);
                    rem_d = rem_q - LEN_WIDTH'(1);
                    // Abort is only honoured here, so a read is always followed by its write
                    if (rem_q == LEN_WIDTH'(1) || abort_q || abort_i) begin
                        state_d = DMA_ST_FIN;
                    end else begin
                        state_d = DMA_ST_RD;
                    end
                end
            end
            default: begin
                abort_d = 1'b0;
                state_d = DMA_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMA_ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs decode straight from state so an async reset drops the request at once
    assign busy_o    = (state_q != DMA_ST_IDLE);
    assign done_o    = (state_q == DMA_ST_FIN);
    assign err_o     = err_q;
    assign m_valid_o = (state_q == DMA_ST_RD) || (state_q == DMA_ST_WR);
    assign m_addr_o  = (state_q == DMA_ST_RD) ? src_q :
                       (state_q == DMA_ST_WR) ? dst_q : '0;
    assign m_we_o    = (state_q == DMA_ST_WR) ? MEM_WE_WORD : MEM_WE_READ;
    assign m_wdata_o = (state_q == DMA_ST_WR) ? buf_q : '0;

endmodule
